// File: rtl/result_deskew_drain.sv
// result_deskew_drain
//
// Output end of the systolic array's skewed-data protocol. The array presents
// its partial-sum columns on a diagonal: for a row strobed at edge t, column c
// is valid at edge t+c. This block delays each column so that all of them line
// up at edge t+M-1. It then pushes the aligned row into a small FIFO and drains
// it through a valid/ready port. Each row is tagged with its results-SRAM
// address. A start/done handshake brackets every tile of rows.
//
// Build option:
//   DESKEW_RELU_EN  when defined, any negative column (sign bit set) is written
//                   into the FIFO as zero. Zero and positive values pass
//                   through unchanged. When undefined, data is bit-exact.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle pulse; latches row_count/base_addr (only in IDLE)
//   row_count  number of rows in the tile
//   base_addr  results-SRAM address of row 0
//   in_valid   row strobe: column 0 of a row is valid this cycle
//   result_in  skewed columns, slice c = column c (signed)
//   out_valid  FIFO head valid
//   out_ready  consumer accepts the head
//   out_data   aligned row at the FIFO head, slice c = column c
//   out_addr   SRAM address of the head row
//   out_last   head row is the final row of the tile
//   busy       FSM is not IDLE
//   done       one-cycle pulse at the end of a tile
//   overflow   sticky: a row was dropped because the FIFO was full
module result_deskew_drain #(
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int ADDRESSSIZE    = 10,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                row_count,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic                                  in_valid,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] result_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] out_data,
    output logic [ADDRESSSIZE-1:0]                out_addr,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow
);

    localparam int BW = PARTIAL_SUM_BW;
    localparam int M  = MATRIX_SIZE;
    localparam int RW = BW * M;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [ADDRESSSIZE-1:0] rows_reg;
    logic [ADDRESSSIZE-1:0] base_reg;
    logic [ADDRESSSIZE-1:0] accepted_reg;
    logic [ADDRESSSIZE-1:0] pop_idx_reg;
    logic                   overflow_reg;

    logic start_ok;
    logic accept;

    // Row strobe delay line: bit k set means a row was accepted k+1 edges ago.
    logic [M-2:0] vld_pipe_reg;

    // Aligned FIFO (register storage so it can be cleared by reset)
    logic [RW-1:0]  mem_reg [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg, count_next;
    logic [RW-1:0]  write_row;
    logic           push, pop, full, wr_en;

    assign start_ok = start && (state_reg == IDLE);
    // Strobes are only meaningful while the tile is still collecting rows.
    assign accept   = in_valid && (state_reg == RUN);

    // ------------------------------------------------------------------
    // Column deskew. Column c waits M-1-c stages. The last column is used
    // straight from the input at the edge on which the row is pushed.
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < M; gi++) begin : g_col
        logic [BW-1:0] col;

        if (gi == M - 1) begin : g_direct
            assign col = result_in[gi*BW +: BW];
        end else begin : g_dly
            localparam int DEPTH = M - 1 - gi;
            logic [BW-1:0] dly_reg [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        dly_reg[k] <= '0;
                    end
                end else begin
                    dly_reg[0] <= result_in[gi*BW +: BW];
                    for (int k = 1; k < DEPTH; k++) begin
                        dly_reg[k] <= dly_reg[k-1];
                    end
                end
            end

            assign col = dly_reg[DEPTH-1];
        end

`ifdef DESKEW_RELU_EN
        assign write_row[gi*BW +: BW] = col[BW-1] ? '0 : col;
`else
        assign write_row[gi*BW +: BW] = col;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_reg <= '0;
        end else begin
            vld_pipe_reg[0] <= accept;
            for (int k = 1; k < M - 1; k++) begin
                vld_pipe_reg[k] <= vld_pipe_reg[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO. When the FIFO is full, a push is still accepted in the same
    // cycle as a pop. Otherwise a push into a full FIFO drops the row.
    // ------------------------------------------------------------------
    assign push      = vld_pipe_reg[M-2];
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count_reg == CW'(FIFO_DEPTH));
    assign wr_en     = push && (!full || pop);

    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_reg[k] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                mem_reg[wr_ptr_reg] <= write_row;
                wr_ptr_reg          <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    assign out_data = mem_reg[rd_ptr_reg];
    // The address wraps naturally at the 2^ADDRESSSIZE boundary.
    assign out_addr = base_reg + pop_idx_reg;
    assign out_last = out_valid && (pop_idx_reg == rows_reg - ADDRESSSIZE'(1));
    assign overflow = overflow_reg;

    // ------------------------------------------------------------------
    // Tile bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_reg     <= '0;
            base_reg     <= '0;
            accepted_reg <= '0;
            pop_idx_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (start_ok) begin
                rows_reg     <= row_count;
                base_reg     <= base_addr;
                accepted_reg <= '0;
                pop_idx_reg  <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (accept) begin
                    accepted_reg <= accepted_reg + ADDRESSSIZE'(1);
                end
                // A dropped row never reaches the FIFO, so it does not use
                // up a pop index.
                if (pop) begin
                    pop_idx_reg <= pop_idx_reg + ADDRESSSIZE'(1);
                end
                if (push && full && !pop) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        done       = (state_reg == DONE);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (row_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Leave on the same edge that accepts the final row.
                if (accept && (accepted_reg == rows_reg - ADDRESSSIZE'(1))) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Look at the post-edge FIFO occupancy so that done follows
                // the final pop immediately.
                if ((vld_pipe_reg == '0) && (count_next == '0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_deskew_drain.sv
// Directed testbench for result_deskew_drain (M=8, 20-bit columns,
// 10-bit addresses, 4-entry FIFO). Inputs are driven 1 time unit after each
// rising edge. Pops and done pulses are recorded at the falling edge and are
// tagged with the number of the rising edge that consumes them.
module tb_result_deskew_drain;

    localparam int BW = 20;
    localparam int M  = 8;
    localparam int AW = 10;
    localparam int RW = BW * M;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, out_ready;
    logic [AW-1:0] row_count, base_addr;
    logic [RW-1:0] result_in;
    logic          out_valid, out_last, busy, done, overflow;
    logic [AW-1:0] out_addr;
    logic [RW-1:0] out_data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    result_deskew_drain #(
        .PARTIAL_SUM_BW(BW), .MATRIX_SIZE(M), .ADDRESSSIZE(AW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .row_count(row_count),
        .base_addr(base_addr), .in_valid(in_valid), .result_in(result_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pop / done recorder
    logic [RW-1:0] cap_data [$];
    logic [AW-1:0] cap_addr [$];
    logic          cap_last [$];
    int            cap_edge [$];
    int            done_cnt  = 0;
    int            done_edge = 0;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_addr.push_back(out_addr);
            cap_last.push_back(out_last);
            cap_edge.push_back(cyc + 1);
            $display("pop  edge=%0d addr=%h last=%0b data=%h", cyc + 1, out_addr, out_last, out_data);
        end
        if (!rst && done) begin
            done_cnt  <= done_cnt + 1;
            done_edge <= cyc + 1;
        end
    end

    // Skew history: entry k holds the row that was strobed k edges ago.
    logic [RW-1:0] hist_row [M];
    bit            hist_v   [M];

    function automatic logic [RW-1:0] mk_row(input int r);
        logic [RW-1:0] v;
        for (int c = 0; c < M; c++) v[c*BW +: BW] = BW'(r * 16 + c + 1);
        return v;
    endfunction

    task automatic clear_caps();
        cap_data.delete(); cap_addr.delete(); cap_last.delete(); cap_edge.delete();
    endtask

    // Present one cycle of skewed input, then advance past the next edge.
    task automatic step(input bit v, input logic [RW-1:0] row);
        for (int k = M - 1; k > 0; k--) begin
            hist_row[k] = hist_row[k-1];
            hist_v[k]   = hist_v[k-1];
        end
        hist_row[0] = row;
        hist_v[0]   = v;
        in_valid    = v;
        for (int c = 0; c < M; c++)
            result_in[c*BW +: BW] = hist_v[c] ? hist_row[c][c*BW +: BW] : 20'hABCDE;
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [AW-1:0] rc, input logic [AW-1:0] ba);
        start = 1'b1; row_count = rc; base_addr = ba;
        step(1'b0, '0);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        row_count = '0; base_addr = '0; result_in = '0;
        for (int k = 0; k < M; k++) begin hist_v[k] = 1'b0; hist_row[k] = '0; end
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, out_last, busy, done, overflow} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=00000", {out_valid, out_last, busy, done, overflow});
        end
        vectors++;
        if ({out_data, out_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got=%h/%h want=0/0", out_data, out_addr);
        end
    endtask

    task automatic test_single_row();
        int se, d0;
        clear_caps(); d0 = done_cnt; out_ready = 1'b1;
        do_start(10'd1, 10'h010);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b want=1", busy); end
        se = cyc + 1;
        step(1'b1, mk_row(0));
        repeat (12) step(1'b0, '0);
        vectors++;
        if (cap_data.size() != 1) begin
            miscompares++; $display("FAIL single_count got=%0d want=1", cap_data.size());
        end else begin
            vectors++;
            if (cap_edge[0] != se + 8) begin miscompares++; $display("FAIL single_latency got=%0d want=%0d", cap_edge[0] - se, 8); end
            vectors++;
            if ({cap_data[0], cap_addr[0], cap_last[0]} !== {mk_row(0), 10'h010, 1'b1}) begin
                miscompares++;
                $display("FAIL single_row got=%h/%h/%b want=%h/010/1", cap_data[0], cap_addr[0], cap_last[0], mk_row(0));
            end
        end
        vectors++;
        if (done_cnt != d0 + 1 || done_edge != se + 9) begin
            miscompares++; $display("FAIL single_done got=%0d@%0d want=%0d@%0d", done_cnt - d0, done_edge, 1, se + 9);
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        int se, d0;
        clear_caps(); d0 = done_cnt; out_ready = 1'b1;
        do_start(10'd4, 10'h100);
        se = cyc + 1;
        for (int r = 0; r < 4; r++) step(1'b1, mk_row(r + 1));
        repeat (14) step(1'b0, '0);
        vectors++;
        if (cap_data.size() != 4) begin
            miscompares++; $display("FAIL b2b_count got=%0d want=4", cap_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if ({cap_edge[i], cap_data[i], cap_addr[i], cap_last[i]} !==
                    {se + 8 + i, mk_row(i + 1), AW'(10'h100 + i), (i == 3)}) begin
                    miscompares++;
                    $display("FAIL b2b_row%0d got=%0d/%h/%h/%b want=%0d/%h/%h/%b", i, cap_edge[i], cap_data[i],
                             cap_addr[i], cap_last[i], se + 8 + i, mk_row(i + 1), 10'h100 + i, (i == 3));
                end
            end
        end
        vectors++;
        if (overflow !== 1'b0 || done_cnt != d0 + 1) begin
            miscompares++; $display("FAIL b2b_end got=ovf%b/done%0d want=ovf0/done1", overflow, done_cnt - d0);
        end
    endtask

    task automatic test_overflow();
        int d0;
        clear_caps(); d0 = done_cnt; out_ready = 1'b0;
        do_start(10'd6, 10'h200);
        for (int r = 0; r < 6; r++) step(1'b1, mk_row(10 + r));
        repeat (10) step(1'b0, '0);
        vectors++;
        if ({overflow, out_valid, out_last, busy} !== 4'b1101) begin
            miscompares++; $display("FAIL ovf_flags got=%b want=1101", {overflow, out_valid, out_last, busy});
        end
        vectors++;
        if ({out_data, out_addr} !== {mk_row(10), 10'h200}) begin
            miscompares++; $display("FAIL ovf_head got=%h/%h want=%h/200", out_data, out_addr, mk_row(10));
        end
        vectors++;
        if (done_cnt != d0 || cap_data.size() != 0) begin
            miscompares++; $display("FAIL ovf_early got=done%0d/pops%0d want=done0/pops0", done_cnt - d0, cap_data.size());
        end
        repeat (3) step(1'b0, '0);
        vectors++;
        if ({out_data, out_addr, out_valid} !== {mk_row(10), 10'h200, 1'b1}) begin
            miscompares++; $display("FAIL ovf_stall got=%h/%h/%b want=%h/200/1", out_data, out_addr, out_valid, mk_row(10));
        end
        out_ready = 1'b1;
        repeat (8) step(1'b0, '0);
        vectors++;
        if (cap_data.size() != 4) begin
            miscompares++; $display("FAIL ovf_count got=%0d want=4", cap_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if ({cap_data[i], cap_addr[i], cap_last[i]} !== {mk_row(10 + i), AW'(10'h200 + i), 1'b0}) begin
                    miscompares++;
                    $display("FAIL ovf_row%0d got=%h/%h/%b want=%h/%h/0", i, cap_data[i], cap_addr[i], cap_last[i],
                             mk_row(10 + i), 10'h200 + i);
                end
            end
        end
        vectors++;
        if ({overflow, busy} !== 2'b10 || done_cnt != d0 + 1) begin
            miscompares++; $display("FAIL ovf_end got=ovf%b/busy%b/done%0d want=ovf1/busy0/done1", overflow, busy, done_cnt - d0);
        end
    endtask

    task automatic test_addr_wrap();
        clear_caps(); out_ready = 1'b1;
        do_start(10'd3, 10'h3FE);
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_ovf_clear got=%b want=0", overflow); end
        for (int r = 0; r < 3; r++) step(1'b1, mk_row(20 + r));
        repeat (14) step(1'b0, '0);
        vectors++;
        if (cap_data.size() != 3) begin
            miscompares++; $display("FAIL wrap_count got=%0d want=3", cap_data.size());
        end else begin
            vectors++;
            if ({cap_addr[0], cap_addr[1], cap_addr[2]} !== {10'h3FE, 10'h3FF, 10'h000}) begin
                miscompares++; $display("FAIL wrap_addr got=%h,%h,%h want=3fe,3ff,000", cap_addr[0], cap_addr[1], cap_addr[2]);
            end
            vectors++;
            if ({cap_last[0], cap_last[1], cap_last[2]} !== 3'b001 || cap_data[2] !== mk_row(22)) begin
                miscompares++; $display("FAIL wrap_last got=%b%b%b/%h want=001/%h", cap_last[0], cap_last[1], cap_last[2], cap_data[2], mk_row(22));
            end
        end
    endtask

    task automatic test_signed();
        logic [RW-1:0] row, want;
        clear_caps(); out_ready = 1'b1;
        row[0*BW +: BW] = 20'hFFFFB;  // -5
        row[1*BW +: BW] = 20'h00007;  // +7
        row[2*BW +: BW] = 20'hFFFFF;  // -1
        row[3*BW +: BW] = 20'h00000;
        row[4*BW +: BW] = 20'h00001;
        row[5*BW +: BW] = 20'h80000;  // most negative
        row[6*BW +: BW] = 20'h7FFFF;  // most positive
        row[7*BW +: BW] = 20'h00003;
`ifdef DESKEW_RELU_EN
        want = row;
        want[0*BW +: BW] = '0;
        want[2*BW +: BW] = '0;
        want[5*BW +: BW] = '0;
`else
        want = row;
`endif
        do_start(10'd1, 10'h0AB);
        step(1'b1, row);
        repeat (12) step(1'b0, '0);
        vectors++;
        if (cap_data.size() != 1) begin
            miscompares++; $display("FAIL signed_count got=%0d want=1", cap_data.size());
        end else begin
            vectors++;
            if (cap_data[0] !== want) begin
                miscompares++; $display("FAIL signed_data got=%h want=%h", cap_data[0], want);
            end
        end
    endtask

    task automatic test_zero_rows();
        int d0;
        clear_caps(); d0 = done_cnt; out_ready = 1'b1;
        do_start(10'd0, 10'h123);
        vectors++;
        if ({busy, done} !== 2'b11) begin miscompares++; $display("FAIL zero_done got=%b want=11", {busy, done}); end
        step(1'b0, '0);
        vectors++;
        if ({busy, done} !== 2'b00 || done_cnt != d0 + 1) begin
            miscompares++; $display("FAIL zero_end got=%b/%0d want=00/1", {busy, done}, done_cnt - d0);
        end
        // A strobe while IDLE must not produce a row.
        step(1'b1, mk_row(30));
        repeat (12) step(1'b0, '0);
        vectors++;
        if (cap_data.size() != 0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL idle_strobe got=pops%0d/valid%b want=pops0/valid0", cap_data.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid_tile();
        int se;
        clear_caps(); out_ready = 1'b0;
        do_start(10'd4, 10'h055);
        for (int r = 0; r < 4; r++) step(1'b1, mk_row(40 + r));
        repeat (10) step(1'b0, '0);
        vectors++;
        if ({out_valid, busy, out_addr} !== {1'b1, 1'b1, 10'h055}) begin
            miscompares++; $display("FAIL midrst_pre got=%b%b/%h want=11/055", out_valid, busy, out_addr);
        end
        #2; rst = 1'b1; #1;
        vectors++;
        if ({out_valid, out_last, busy, done, overflow, out_data, out_addr} !== '0) begin
            miscompares++;
            $display("FAIL midrst_async got=%b%b%b%b%b/%h/%h want=all0", out_valid, out_last, busy, done, overflow, out_data, out_addr);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        for (int k = 0; k < M; k++) hist_v[k] = 1'b0;
        clear_caps(); out_ready = 1'b1;
        do_start(10'd1, 10'h077);
        se = cyc + 1;
        step(1'b1, mk_row(44));
        repeat (12) step(1'b0, '0);
        vectors++;
        if (cap_data.size() != 1) begin
            miscompares++; $display("FAIL midrst_count got=%0d want=1", cap_data.size());
        end else begin
            vectors++;
            if ({cap_edge[0], cap_data[0], cap_addr[0], cap_last[0]} !== {se + 8, mk_row(44), 10'h077, 1'b1}) begin
                miscompares++;
                $display("FAIL midrst_row got=%0d/%h/%h/%b want=%0d/%h/077/1", cap_edge[0], cap_data[0], cap_addr[0], cap_last[0], se + 8, mk_row(44));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_back_to_back();
        test_overflow();
        test_addr_wrap();
        test_signed();
        test_zero_rows();
        test_reset_mid_tile();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
